ysyx_23060184_clint_slave: RTL

// AXI4-Lite responder (slave) for the core-local interruptor (CLINT), on the DataMem data-bus master port beside SRAM and UART.

---
 rtl/ysyx_23060184_clint_slave.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/ysyx_23060184_clint_slave.sv
// CLINT responder on the data bus: mtime/mtimecmp/msip behind AXI4-Lite, with timer and software interrupts.
// Reads answer one cycle after accept; writes answer one cycle after both AW and W are held.
module ysyx_23060184_clint_slave #(
    parameter logic [31:0] BASE_ADDR       = 32'h0200_0000,
    parameter int          TICK_DIV        = 1,
    parameter int          GRANT_IDX       = 1,
    parameter int          NUM_ARB_MASTERS = 2,
    parameter int          DATA_WIDTH      = 32,
    parameter int          ACERR_WIDTH     = 2,
    parameter int          WMASK_LENGTH    = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_ARB_MASTERS-1:0] grant,
    input  logic [DATA_WIDTH-1:0]      araddr,
    input  logic                       arvalid,
    output logic                       aready,
    output logic [DATA_WIDTH-1:0]      rdata,
    output logic [ACERR_WIDTH-1:0]     rresp,
    output logic                       rvalid,
    input  logic                       rready,
    input  logic [DATA_WIDTH-1:0]      awaddr,
    input  logic                       awvalid,
    output logic                       awready,
    input  logic [DATA_WIDTH-1:0]      wdata,
    input  logic [WMASK_LENGTH-1:0]    wstrb,
    input  logic                       wvalid,
    output logic                       wready,
    output logic [ACERR_WIDTH-1:0]     bresp,
    output logic                       bvalid,
    input  logic                       bready,
    output logic                       timer_irq,
    output logic                       soft_irq
);
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [1:0]  RESP_DECERR = 2'b11;
    localparam logic [15:0] OFF_MSIP    = 16'h0000;
    localparam logic [15:0] OFF_CMP_LO  = 16'h4000;
    localparam logic [15:0] OFF_CMP_HI  = 16'h4004;
    localparam logic [15:0] OFF_TIME_LO = 16'hBFF8;
    localparam logic [15:0] OFF_TIME_HI = 16'hBFFC;
    localparam int          PW          = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    typedef enum logic { R_IDLE, R_RESP } r_state_t;
    typedef enum logic { W_IDLE, W_RESP } w_state_t;

    r_state_t    r_state_q, r_state_d;
    w_state_t    w_state_q, w_state_d;
    logic [63:0] mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
    logic [31:0] shadow_q, shadow_d, rdata_q, rdata_d, wdata_q, wdata_d;
    logic [15:0] awaddr_q, awaddr_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [1:0]  rresp_q, rresp_d, bresp_q, bresp_d;
    logic [PW-1:0] presc_q, presc_d;
    logic        msip_q, msip_d, rvalid_q, rvalid_d, bvalid_q, bvalid_d;
    logic        aw_done_q, aw_done_d, w_done_q, w_done_d, timer_irq_q, timer_irq_d;

    logic        ar_hs, aw_hs, w_hs, wr_fire, wr_ok, tick;
    logic [31:0] rd_dat, wr_dat;
    logic [15:0] wr_off;
    logic [3:0]  wr_strb;
    logic [1:0]  rd_resp, wr_resp;
    logic        grant_unused;

    assign grant_unused = ^grant;

    function automatic logic in_window(input logic [31:0] a);
        return a[31:16] == BASE_ADDR[31:16];
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] strb);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = strb[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        return m;
    endfunction

    function automatic logic [1:0] decode(input logic [15:0] off);
        if (off[1:0] != 2'b00) return RESP_SLVERR;
        case (off)
            OFF_MSIP, OFF_CMP_LO, OFF_CMP_HI, OFF_TIME_LO, OFF_TIME_HI: return RESP_OKAY;
            default: return RESP_DECERR;
        endcase
    endfunction

    assign aready  = (r_state_q == R_IDLE) & grant[GRANT_IDX] & in_window(araddr);
    assign awready = (w_state_q == W_IDLE) & grant[GRANT_IDX] & ~aw_done_q & in_window(awaddr);
    assign wready  = (w_state_q == W_IDLE) & grant[GRANT_IDX] & ~w_done_q;
    assign ar_hs   = arvalid & aready;
    assign aw_hs   = awvalid & awready;
    assign w_hs    = wvalid & wready;

    // A half captured in this very cycle is used straight from the bus.
    assign wr_off  = aw_done_q ? awaddr_q : awaddr[15:0];
    assign wr_dat  = w_done_q ? wdata_q : wdata;
    assign wr_strb = w_done_q ? wstrb_q : wstrb;
    assign wr_fire = (w_state_q == W_IDLE) & (aw_done_q | aw_hs) & (w_done_q | w_hs);
    assign wr_resp = decode(wr_off);
    assign wr_ok   = wr_fire & (wr_resp == RESP_OKAY);
    assign tick    = (presc_q == PRESC_MAX);

    always_comb begin
        rd_resp = decode(araddr[15:0]);
        rd_dat  = 32'h0;
        if (rd_resp == RESP_OKAY) begin
            case (araddr[15:0])
                OFF_MSIP:    rd_dat = {31'h0, msip_q};
                OFF_CMP_LO:  rd_dat = mtimecmp_q[31:0];
                OFF_CMP_HI:  rd_dat = mtimecmp_q[63:32];
                OFF_TIME_LO: rd_dat = mtime_q[31:0];
                default:     rd_dat = shadow_q;
            endcase
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        shadow_d  = shadow_q;
        if (ar_hs) begin
            r_state_d = R_RESP;
            rvalid_d  = 1'b1;
            rdata_d   = rd_dat;
            rresp_d   = rd_resp;
            if (rd_resp == RESP_OKAY && araddr[15:0] == OFF_TIME_LO) shadow_d = mtime_q[63:32];
        end else if (r_state_q == R_RESP && rready) begin
            r_state_d = R_IDLE;
            rvalid_d  = 1'b0;
        end
    end

    always_comb begin
        w_state_d = w_state_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        if (aw_hs) begin
            aw_done_d = 1'b1;
            awaddr_d  = awaddr[15:0];
        end
        if (w_hs) begin
            w_done_d = 1'b1;
            wdata_d  = wdata;
            wstrb_d  = wstrb;
        end
        if (wr_fire) begin
            w_state_d = W_RESP;
            bvalid_d  = 1'b1;
            bresp_d   = wr_resp;
        end else if (w_state_q == W_RESP && bready) begin
            w_state_d = W_IDLE;
            bvalid_d  = 1'b0;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
        end
    end

    // A software write to mtime overrides the tick; unwritten bytes keep the pre-increment value.
    always_comb begin
        presc_d    = tick ? '0 : presc_q + 1'b1;
        mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
        mtimecmp_d = mtimecmp_q;
        msip_d     = msip_q;
        if (wr_ok) begin
            case (wr_off)
                OFF_MSIP:    if (wr_strb[0]) msip_d = wr_dat[0];
                OFF_CMP_LO:  mtimecmp_d[31:0]  = merge(mtimecmp_q[31:0], wr_dat, wr_strb);
                OFF_CMP_HI:  mtimecmp_d[63:32] = merge(mtimecmp_q[63:32], wr_dat, wr_strb);
                OFF_TIME_LO: mtime_d = {mtime_q[63:32], merge(mtime_q[31:0], wr_dat, wr_strb)};
                OFF_TIME_HI: mtime_d = {merge(mtime_q[63:32], wr_dat, wr_strb), mtime_q[31:0]};
                default: ;
            endcase
        end
        timer_irq_d = (mtime_q >= mtimecmp_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q   <= R_IDLE;
            w_state_q   <= W_IDLE;
            mtime_q     <= 64'h0;
            mtimecmp_q  <= 64'hFFFF_FFFF_FFFF_FFFF;
            shadow_q    <= 32'h0;
            rdata_q     <= 32'h0;
            wdata_q     <= 32'h0;
            awaddr_q    <= 16'h0;
            wstrb_q     <= 4'h0;
            rresp_q     <= RESP_OKAY;
            bresp_q     <= RESP_OKAY;
            presc_q     <= '0;
            msip_q      <= 1'b0;
            rvalid_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            timer_irq_q <= 1'b0;
        end else begin
            r_state_q   <= r_state_d;
            w_state_q   <= w_state_d;
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            shadow_q    <= shadow_d;
            rdata_q     <= rdata_d;
            wdata_q     <= wdata_d;
            awaddr_q    <= awaddr_d;
            wstrb_q     <= wstrb_d;
            rresp_q     <= rresp_d;
            bresp_q     <= bresp_d;
            presc_q     <= presc_d;
            msip_q      <= msip_d;
            rvalid_q    <= rvalid_d;
            bvalid_q    <= bvalid_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            timer_irq_q <= timer_irq_d;
        end
    end

    assign rdata     = rdata_q;
    assign rresp     = rresp_q;
    assign rvalid    = rvalid_q;
    assign bresp     = bresp_q;
    assign bvalid    = bvalid_q;
    assign timer_irq = timer_irq_q;
    assign soft_irq  = msip_q;
endmodule
